gf2m_mul163_arbiter: RTL and testbench

- Shares the single pipelined GF(2^163) multiplier (gf2m_mult163) between NREQ requesters, e.g. the inverter, point-add and point-double sequencers.
- Round-robin grant; at most one operation issued per cycle.
- Tracks the owner of each in-flight operation in a tag pipeline that matches the multiplier latency.
- Returns each product, registered, to the requester that issued it.

---
 rtl/gf2m_mul163_arbiter.sv | 117 +++++++++++
 tb/tb_gf2m_mul163_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_mul163_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : gf2m_mul163_arbiter
// Brief    : Round-robin sharing of one pipelined GF(2^163) multiplier among
//            NREQ requesters; a tag pipeline routes each product to its issuer.
// Revision : 1.0
// =============================================================================
module gf2m_mul163_arbiter #(
    parameter int M       = 163,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 3,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*M-1:0]   req_a,
    input  logic [NREQ*M-1:0]   req_b,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [M-1:0]        rsp_data,
    output logic [IDW-1:0]      rsp_id,
    output logic [M-1:0]        mul_a,
    output logic [M-1:0]        mul_b,
    input  logic [M-1:0]        mul_res,
    output logic                busy
);

    localparam int NTAG = MUL_LAT + 1;

    logic [IDW-1:0]            ptr_q, ptr_d;
    logic [M-1:0]              mul_a_q, mul_a_d;
    logic [M-1:0]              mul_b_q, mul_b_d;
    logic [NTAG-1:0]           tag_vld_q, tag_vld_d;
    logic [NTAG-1:0][IDW-1:0]  tag_id_q, tag_id_d;
    logic [NREQ-1:0]           rsp_valid_q, rsp_valid_d;
    logic [M-1:0]              rsp_data_q, rsp_data_d;
    logic [IDW-1:0]            rsp_id_q, rsp_id_d;

    logic                      w_gnt_any;
    logic [IDW-1:0]            w_gnt_id;
    logic [IDW:0]              w_idx;

    // Search upward from the pointer; one extra bit keeps ptr+k from overflowing before the wrap.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ)) begin
                w_idx = w_idx - (IDW+1)'(NREQ);
            end
            if (!w_gnt_any && req[w_idx[IDW-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = w_idx[IDW-1:0];
            end
        end
    end

    assign gnt = (rst || !w_gnt_any) ? '0 : (NREQ'(1) << w_gnt_id);

    always_comb begin
        ptr_d   = ptr_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (w_gnt_any) begin
            ptr_d   = (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + IDW'(1);
            mul_a_d = req_a[int'(w_gnt_id)*M +: M];
            mul_b_d = req_b[int'(w_gnt_id)*M +: M];
        end

        tag_vld_d = {tag_vld_q[NTAG-2:0], w_gnt_any};
        tag_id_d  = {tag_id_q[NTAG-2:0], w_gnt_id};

        // The last tag stage is aligned with mul_res for the op it describes.
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (tag_vld_q[NTAG-1]) begin
            rsp_valid_d = NREQ'(1) << tag_id_q[NTAG-1];
            rsp_data_d  = mul_res;
            rsp_id_d    = tag_id_q[NTAG-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (|tag_vld_q) | (|rsp_valid_q);

endmodule
`default_nettype wire

// File: tb/tb_gf2m_mul163_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_gf2m_mul163_arbiter
// Brief    : Directed bench for gf2m_mul163_arbiter with a behavioural multiplier
//            and a queue-based response scoreboard.
// Revision : 1.0
// =============================================================================
module tb_gf2m_mul163_arbiter;

    localparam int M       = 163;
    localparam int NREQ    = 4;
    localparam int MUL_LAT = 3;
    localparam int IDW     = 2;
    localparam logic [M-1:0] C_POLY_LOW = 163'hC9;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*M-1:0]  req_a;
    logic [NREQ*M-1:0]  req_b;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [M-1:0]       rsp_data;
    logic [IDW-1:0]     rsp_id;
    logic [M-1:0]       mul_a;
    logic [M-1:0]       mul_b;
    logic [M-1:0]       mul_res;
    logic               busy;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    typedef struct {
        int          id;
        logic [M-1:0] data;
        int          due;
    } exp_t;

    exp_t            q[$];
    exp_t            e;
    int              mptr = 0;
    int              idx;
    logic [NREQ-1:0] exp_gnt;
    logic [M-1:0]    mp [MUL_LAT];
    logic [M-1:0]    hi_bit;

    gf2m_mul163_arbiter #(
        .M(M), .NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDW(IDW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shift-and-add multiply modulo x^163 + x^7 + x^6 + x^3 + 1.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M-1:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ x;
            if (x[M-1]) x = (x << 1) ^ C_POLY_LOW;
            else        x = x << 1;
        end
        return r;
    endfunction

    // Behavioural pipelined multiplier: MUL_LAT cycles from mul_a/mul_b to mul_res.
    always @(posedge clk) begin
        mp[0] <= gf_mul(mul_a, mul_b);
        for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
    end
    assign mul_res = mp[MUL_LAT-1];

    task automatic chk(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [M-1:0] a, input logic [M-1:0] b);
        req_a[i*M +: M] = a;
        req_b[i*M +: M] = b;
    endtask

    // Scoreboard: predict grants, push expected products, pop them when due.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_gnt", gnt, '0);
            chk("rst_busy", busy, '0);
            chk("rst_rsp_valid", rsp_valid, '0);
            q.delete();
            mptr = 0;
        end else begin
            chk("busy", busy, M'(q.size() != 0));
            if (q.size() != 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("sb_rsp_valid", rsp_valid, M'(NREQ'(1) << e.id));
                chk("sb_rsp_id", rsp_id, M'(e.id));
                chk("sb_rsp_data", rsp_data, e.data);
            end else begin
                chk("sb_no_rsp", rsp_valid, '0);
            end
            exp_gnt = '0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (mptr + k) % NREQ;
                if (exp_gnt == '0 && req[idx]) begin
                    exp_gnt = NREQ'(1) << idx;
                    e.id    = idx;
                    e.data  = gf_mul(req_a[idx*M +: M], req_b[idx*M +: M]);
                    e.due   = cyc + 2 + MUL_LAT;
                end
            end
            chk("sb_gnt", gnt, M'(exp_gnt));
            if (exp_gnt != '0) begin
                q.push_back(e);
                mptr = (e.id + 1) % NREQ;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        req   = '0;
        req_a = '0;
        req_b = '0;
        hi_bit = '0;
        hi_bit[M-1] = 1'b1;
        step();
        step();
        chk("rst_mul_a", mul_a, '0);
        chk("rst_mul_b", mul_b, '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_id", rsp_id, '0);
        rst = 1'b0;
        step();

        // Single op: 2 * 3 = 6, response five cycles after the grant.
        set_op(0, 163'h2, 163'h3);
        req = 4'b0001;
        #1 chk("single_gnt", gnt, 4'b0001);
        step();
        req = '0;
        repeat (4) step();
        chk("single_rsp_valid", rsp_valid, 4'b0001);
        chk("single_rsp_data", rsp_data, 163'h6);
        chk("single_rsp_id", rsp_id, 0);

        // Reduction: x^162 * x = x^7 + x^6 + x^3 + 1.
        step();
        set_op(2, hi_bit, 163'h2);
        req = 4'b0100;
        #1 chk("red_gnt", gnt, 4'b0100);
        step();
        req = '0;
        repeat (4) step();
        chk("red_rsp_valid", rsp_valid, 4'b0100);
        chk("red_rsp_data", rsp_data, 163'hC9);
        chk("red_rsp_id", rsp_id, 2);

        // Pointer wrap: pointer sits at 3, requesters 3 and 0 pending.
        step();
        set_op(3, 163'd5, 163'd7);
        set_op(0, 163'd9, 163'd11);
        req = 4'b1001;
        #1 chk("wrap_gnt_first", gnt, 4'b1000);
        step();
        #1 chk("wrap_gnt_second", gnt, 4'b0001);
        step();
        req = '0;
        repeat (6) step();

        // Reset with two ops in flight: neither may ever respond.
        set_op(1, 163'd13, 163'd15);
        set_op(2, 163'd17, 163'd19);
        req = 4'b0010;
        #1 chk("rstmid_gnt0", gnt, 4'b0010);
        step();
        req = 4'b0100;
        #1 chk("rstmid_gnt1", gnt, 4'b0100);
        step();
        rst = 1'b1;
        req = 4'b1111;
        #1;
        chk("rstmid_gnt_forced", gnt, '0);
        chk("rstmid_busy", busy, '0);
        step();
        rst = 1'b0;
        req = '0;
        repeat (8) step();
        set_op(3, 163'd21, 163'd23);
        req = 4'b1000;
        #1 chk("post_rst_gnt", gnt, 4'b1000);
        step();
        req = '0;
        repeat (4) step();
        chk("post_rst_rsp_valid", rsp_valid, 4'b1000);
        chk("post_rst_rsp_data", rsp_data, 163'h13B);
        chk("post_rst_rsp_id", rsp_id, 3);

        // Round robin: all four requesting for eight cycles, a = i+1, b = 1.
        step();
        for (int i = 0; i < NREQ; i++) set_op(i, M'(i + 1), 163'd1);
        req = '1;
        for (int k = 0; k < 13; k++) begin
            #1;
            if (k < 8) chk("rr_gnt", gnt, M'(NREQ'(1) << (k % 4)));
            if (k >= 5) begin
                chk("rr_rsp_data", rsp_data, M'((k - 5) % 4 + 1));
                chk("rr_rsp_id", rsp_id, M'((k - 5) % 4));
            end
            step();
            if (k == 7) req = '0;
        end

        // Idle: operand registers hold the last issued pair.
        for (int k = 0; k < 20; k++) begin
            step();
            chk("idle_mul_a", mul_a, 163'd4);
            chk("idle_mul_b", mul_b, 163'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
